// File: rtl/decoder_strobe_pkg.sv
// Shared defaults and FSM state encoding for the strobed one-hot decoder.
package decoder_pkg;

    localparam int INPUT_LENGTH  = 4;
    localparam int OUTPUT_LENGTH = 16;
    localparam int COUNT_WIDTH   = 8;
    localparam int HOLD_W        = 8;   // wide enough for HOLD_CYCLES-1 up to 254

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/decoder_strobe_onehot_decode.sv
// Purely combinational binary-to-one-hot decode; code 0 maps to bit 0.
module onehot_decode
    import decoder_pkg::*;
#(
    parameter int IN_W  = INPUT_LENGTH,
    parameter int OUT_W = OUTPUT_LENGTH
) (
    input  logic [IN_W-1:0]  code,
    output logic [OUT_W-1:0] onehot
);

    // One comparator per select line keeps the decode flat and glitch-free once registered.
    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign onehot[i] = (code == IN_W'(i));
    end

endmodule

// File: rtl/decoder_strobe.sv
// Registered 4-to-16 one-hot decoder: accepts a code on valid/ready and
// holds the matching select line for HOLD_CYCLES clocks, with an accept counter.
module decoder_strobe
    import decoder_pkg::*;
#(
    parameter int INPUT_LENGTH  = decoder_pkg::INPUT_LENGTH,
    parameter int OUTPUT_LENGTH = decoder_pkg::OUTPUT_LENGTH,
    parameter int HOLD_CYCLES   = 4,
    parameter int COUNT_WIDTH   = decoder_pkg::COUNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [INPUT_LENGTH-1:0]  input_wire,
    input  logic                     input_valid,
    output logic                     input_ready,
    output logic [OUTPUT_LENGTH-1:0] output_wire,
    output logic                     output_valid,
    output logic [COUNT_WIDTH-1:0]   accept_count
);

    if (OUTPUT_LENGTH != 2 ** INPUT_LENGTH) begin : g_bad_width
        $error("decoder_strobe: OUTPUT_LENGTH must equal 2**INPUT_LENGTH");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("decoder_strobe: HOLD_CYCLES must be in 1..255");
    end

    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic [OUTPUT_LENGTH-1:0] out_q, out_d;
    logic                     out_vld_q, out_vld_d;
    logic [COUNT_WIDTH-1:0]   acc_cnt_q, acc_cnt_d;
    logic [OUTPUT_LENGTH-1:0] decoded;
    logic                     accept;

    onehot_decode #(
        .IN_W  (INPUT_LENGTH),
        .OUT_W (OUTPUT_LENGTH)
    ) u_decode (
        .code   (input_wire),
        .onehot (decoded)
    );

    // Ready depends only on state and enable, never on input_valid, so no comb loop back to the source.
    always_comb begin
        input_ready = enable && ((state_q == IDLE) || (hold_cnt_q == '0));
    end

    assign accept = input_valid && input_ready;

    // Next-state, hold counter and strobe data; disable overrides everything and forces idle.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        out_d      = out_q;
        if (!enable) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            out_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        out_d      = decoded;
                        hold_cnt_d = HOLD_RELOAD;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end else if (accept) begin
                        // Back-to-back reload: new code replaces old with no zero gap.
                        out_d      = decoded;
                        hold_cnt_d = HOLD_RELOAD;
                    end else begin
                        out_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    out_d      = '0;
                end
            endcase
        end
    end

    // Valid flag and accept counter, registered alongside the strobe.
    always_comb begin
        out_vld_d = |out_d;
        acc_cnt_d = acc_cnt_q + COUNT_WIDTH'(accept);
    end

    // State and datapath registers; async reset clears outputs mid-strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            acc_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            acc_cnt_q  <= acc_cnt_d;
        end
    end

    assign output_wire  = out_q;
    assign output_valid = out_vld_q;
    assign accept_count = acc_cnt_q;

endmodule

// File: tb/tb_decoder_strobe.sv
// Directed bench for decoder_strobe: a per-cycle vector table plus hand
// sequences for async reset, counter wrap and the single-cycle hold build.
module tb_decoder_strobe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, input_valid, input_ready, output_valid;
    logic [3:0]  input_wire;
    logic [15:0] output_wire;
    logic [7:0]  accept_count;

    logic        en1, vld1, rdy1, ovld1;
    logic [3:0]  code1;
    logic [15:0] out1;
    logic [7:0]  cnt1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder_strobe #(.HOLD_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .input_wire   (input_wire),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .output_wire  (output_wire),
        .output_valid (output_valid),
        .accept_count (accept_count)
    );

    decoder_strobe #(.HOLD_CYCLES(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (en1),
        .input_wire   (code1),
        .input_valid  (vld1),
        .input_ready  (rdy1),
        .output_wire  (out1),
        .output_valid (ovld1),
        .accept_count (cnt1)
    );

    typedef struct {
        logic        en;
        logic        vld;
        logic [3:0]  code;
        logic        exp_ready;   // before the edge
        logic [15:0] exp_out;     // after the edge
        logic [7:0]  exp_cnt;     // after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic vld, input logic [3:0] code,
                       input logic rdy, input logic [15:0] out, input logic [7:0] cnt);
        vec_t v;
        v.en = en; v.vld = vld; v.code = code;
        v.exp_ready = rdy; v.exp_out = out; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    // Drives at posedge+1, checks ready before the edge and registered outputs #1 after it.
    task automatic apply(input vec_t v, input int idx);
        enable = v.en; input_valid = v.vld; input_wire = v.code;
        #1;
        check($sformatf("v%0d ready", idx), 32'(input_ready), 32'(v.exp_ready));
        @(posedge clk); #1;
        check($sformatf("v%0d out", idx), 32'(output_wire), 32'(v.exp_out));
        check($sformatf("v%0d out_valid", idx), 32'(output_valid), 32'(v.exp_out != 0));
        check($sformatf("v%0d count", idx), 32'(accept_count), 32'(v.exp_cnt));
    endtask

    initial begin
        logic [7:0] cnt;
        rst_n = 1'b0; enable = 1'b1; input_valid = 1'b0; input_wire = '0;
        en1 = 1'b0; vld1 = 1'b0; code1 = '0;
        #1;
        check("reset out", 32'(output_wire), 32'h0);
        check("reset out_valid", 32'(output_valid), 32'h0);
        check("reset count", 32'(accept_count), 32'h0);
        check("reset ready follows enable", 32'(input_ready), 32'h1);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single code 5: four clocks high, ready low on the first three hold cycles.
        add(1, 1, 4'h5, 1, 16'h0020, 1);
        add(1, 0, 4'h5, 0, 16'h0020, 1);
        add(1, 0, 4'h5, 0, 16'h0020, 1);
        add(1, 0, 4'h5, 0, 16'h0020, 1);
        add(1, 0, 4'h5, 1, 16'h0000, 1);
        add(1, 0, 4'hF, 1, 16'h0000, 1);   // code change without valid is ignored
        // Sweep with valid held; codes scrambled during hold must not be sampled.
        cnt = 8'd1;
        for (int k = 0; k < 16; k++) begin
            cnt++;
            add(1, 1, 4'(k), 1, 16'h1 << k, cnt);
            for (int h = 0; h < 3; h++) add(1, 1, ~4'(k), 0, 16'h1 << k, cnt);
        end
        add(1, 0, 4'h0, 1, 16'h0000, cnt);
        // Disable on the second hold cycle, then re-enable with code 3.
        add(1, 1, 4'hA, 1, 16'h0400, 8'd18);
        add(1, 0, 4'hA, 0, 16'h0400, 8'd18);
        add(0, 1, 4'h7, 0, 16'h0000, 8'd18);
        add(0, 1, 4'h7, 0, 16'h0000, 8'd18);
        add(1, 1, 4'h3, 1, 16'h0008, 8'd19);
        add(1, 0, 4'h3, 0, 16'h0008, 8'd19);
        add(1, 0, 4'h3, 0, 16'h0008, 8'd19);
        add(1, 0, 4'h3, 0, 16'h0008, 8'd19);
        add(1, 0, 4'h3, 1, 16'h0000, 8'd19);

        foreach (vecs[i]) apply(vecs[i], i);

        // Async reset mid-strobe clears everything before the next edge.
        enable = 1'b1; input_valid = 1'b1; input_wire = 4'h8;
        @(posedge clk); #1;
        input_valid = 1'b0;
        check("arst pre out", 32'(output_wire), 32'h0100);
        #2 rst_n = 1'b0;
        #1;
        check("arst out", 32'(output_wire), 32'h0);
        check("arst out_valid", 32'(output_valid), 32'h0);
        check("arst count", 32'(accept_count), 32'h0);
        #2 rst_n = 1'b1;
        #1;
        check("arst ready", 32'(input_ready), 32'h1);
        @(posedge clk); #1;
        check("arst stays idle", 32'(output_wire), 32'h0);

        // Counter wrap: 256 back-to-back accepts of code 2.
        input_valid = 1'b1; input_wire = 4'h2;
        repeat (4 * 254 + 1) @(posedge clk);
        #1;
        check("wrap count 255", 32'(accept_count), 32'd255);
        repeat (4) @(posedge clk);
        #1;
        check("wrap count 0", 32'(accept_count), 32'd0);
        check("wrap out", 32'(output_wire), 32'h0004);
        input_valid = 1'b0;

        // HOLD_CYCLES=1 build: a new code every clock.
        en1 = 1'b1; vld1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            code1 = 4'(k);
            #1;
            check($sformatf("h1 ready %0d", k), 32'(rdy1), 32'h1);
            @(posedge clk); #1;
            check($sformatf("h1 out %0d", k), 32'(out1), 32'(16'h1 << k));
        end
        vld1 = 1'b0;
        #1;
        check("h1 ready after", 32'(rdy1), 32'h1);
        @(posedge clk); #1;
        check("h1 release", 32'(out1), 32'h0);
        check("h1 out_valid", 32'(ovld1), 32'h0);
        check("h1 count", 32'(cnt1), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
